// File: rtl/apb_rr_master.sv
// rtl/apb_rr_master.sv - round-robin APB master sharing one register bus between NUM_REQ requesters
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req, req_write        per-requester request level and direction (1 = write)
//   req_addr/wdata/strb   flattened per-requester fields, requester i at slice i
//   ack                   one-hot completion pulse to the owning requester
//   rsp_rdata, rsp_err    read data (reads only) and timeout flag, valid with ack
//   psel..pstrb           registered APB master outputs
//   prdata, pready        APB slave response
module apb_rr_master #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 12,
   parameter int TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*32-1:0]     req_wdata,
   input  logic [NUM_REQ*4-1:0]      req_strb,
   output logic [NUM_REQ-1:0]        ack,
   output logic [31:0]               rsp_rdata,
   output logic                      rsp_err,
   output logic                      psel,
   output logic                      penable,
   output logic                      pwrite,
   output logic [ADDR_W-1:0]         paddr,
   output logic [31:0]               pwdata,
   output logic [3:0]                pstrb,
   input  logic [31:0]               prdata,
   input  logic                      pready
);

   localparam int OWN_W = $clog2(NUM_REQ);
   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS
   } state_t;

   state_t               state_q, state_d;
   logic [OWN_W-1:0]     owner_q, owner_d;
   logic [OWN_W-1:0]     last_owner_q, last_owner_d;
   logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
   logic                 psel_q, psel_d;
   logic                 penable_q, penable_d;
   logic                 pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]    paddr_q, paddr_d;
   logic [31:0]          pwdata_q, pwdata_d;
   logic [3:0]           pstrb_q, pstrb_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic [31:0]          rsp_rdata_q, rsp_rdata_d;
   logic                 rsp_err_q, rsp_err_d;

   logic [NUM_REQ-1:0]   owner_oh;
   logic [NUM_REQ-1:0]   cand;
   logic [OWN_W-1:0]     idx;
   logic [OWN_W-1:0]     winner;
   logic                 found;
   logic                 g_write;
   logic [ADDR_W-1:0]    g_addr;
   logic [31:0]          g_wdata;
   logic [3:0]           g_strb;

   assign owner_oh = NUM_REQ'(1) << owner_q;

   // The requester just acked still holds req for one more cycle, so it is
   // masked out: the current owner while ACCESS completes, the acked one in IDLE.
   assign cand = (state_q == S_ACCESS) ? (req & ~owner_oh) : (req & ~ack_q);

   // Round-robin search from last_owner+1. Walking offsets downward lets the
   // closest pending requester overwrite any farther one.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int off = NUM_REQ; off >= 1; off--) begin
         idx = OWN_W'((int'(last_owner_q) + off) % NUM_REQ);
         if (cand[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      g_write = 1'b0;
      g_addr  = '0;
      g_wdata = '0;
      g_strb  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == OWN_W'(i)) begin
            g_write = req_write[i];
            g_addr  = req_addr[i*ADDR_W +: ADDR_W];
            g_wdata = req_wdata[i*32 +: 32];
            g_strb  = req_strb[i*4 +: 4];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      wait_cnt_d   = wait_cnt_q;
      psel_d       = psel_q;
      penable_d    = penable_q;
      pwrite_d     = pwrite_q;
      paddr_d      = paddr_q;
      pwdata_d     = pwdata_q;
      pstrb_d      = pstrb_q;
      ack_d        = '0;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_err_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            if (found) begin
               state_d      = S_SETUP;
               psel_d       = 1'b1;
               owner_d      = winner;
               last_owner_d = winner;
               wait_cnt_d   = '0;
               pwrite_d     = g_write;
               paddr_d      = g_addr;
               pwdata_d     = g_wdata;
               pstrb_d      = g_strb;
            end
         end

         S_SETUP: begin
            state_d   = S_ACCESS;
            penable_d = 1'b1;
         end

         S_ACCESS: begin
            if (pready) begin
               ack_d = owner_oh;
               if (!pwrite_q) begin
                  rsp_rdata_d = prdata;
               end
               if (found) begin
                  // Back-to-back: next SETUP overlaps this ack.
                  state_d      = S_SETUP;
                  psel_d       = 1'b1;
                  penable_d    = 1'b0;
                  owner_d      = winner;
                  last_owner_d = winner;
                  wait_cnt_d   = '0;
                  pwrite_d     = g_write;
                  paddr_d      = g_addr;
                  pwdata_d     = g_wdata;
                  pstrb_d      = g_strb;
               end else begin
                  state_d   = S_IDLE;
                  psel_d    = 1'b0;
                  penable_d = 1'b0;
               end
            end else if ((TIMEOUT != 0) && (wait_cnt_q == CNT_W'(TIMEOUT))) begin
               ack_d     = owner_oh;
               rsp_err_d = 1'b1;
               state_d   = S_IDLE;
               psel_d    = 1'b0;
               penable_d = 1'b0;
            end else if (TIMEOUT != 0) begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d   = S_IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         owner_q      <= '0;
         last_owner_q <= OWN_W'(NUM_REQ - 1);
         wait_cnt_q   <= '0;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         pstrb_q      <= '0;
         ack_q        <= '0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         wait_cnt_q   <= wait_cnt_d;
         psel_q       <= psel_d;
         penable_q    <= penable_d;
         pwrite_q     <= pwrite_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
         pstrb_q      <= pstrb_d;
         ack_q        <= ack_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign psel      = psel_q;
   assign penable   = penable_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign pstrb     = pstrb_q;
   assign ack       = ack_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_rr_master.md
# apb_rr_master

Round-robin APB master that shares one APB register bus between NUM_REQ internal requesters. It serialises their read/write requests into APB SETUP/ACCESS sequences and returns completion, read data and error status to the granted requester. It sits upstream of the register-file APB slave, which derives wr_en/rd_en from pready and applies pstrb byte masking to pwdata. A bounded-wait timeout keeps the bus from hanging on a missing pready.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_W, 12: APB address width.
- TIMEOUT, 16: ACCESS cycles with pready low before abort; 0 disables the timeout.
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  request level per requester; held high until its ack.
- req_write  in  NUM_REQ  1 = write, 0 = read, per requester.
- req_addr  in  NUM_REQ*ADDR_W  flattened address; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*32  flattened write data.
- req_strb  in  NUM_REQ*4  flattened byte strobes.
- ack  out  NUM_REQ  one-cycle, one-hot completion pulse to the owning requester.
- rsp_rdata  out  32  read data; valid while ack is high for a read.
- rsp_err  out  1  high with ack when the transfer timed out.
- psel, penable, pwrite  out  1 each  APB control.
- paddr  out  ADDR_W  APB address.
- pwdata  out  32  APB write data.
- pstrb  out  4  APB byte strobes.
- prdata  in  32  APB read data.
- pready  in  1  APB ready; may be combinational from psel/penable.

## Operation
- Registered FSM with states IDLE, SETUP and ACCESS. All APB and response outputs are registered.
- IDLE: psel=0, penable=0.
  - If any req bit is high, the arbiter picks the winner.
  - The winner's write/addr/wdata/strb are latched into pwrite/paddr/pwdata/pstrb.
  - The FSM moves to SETUP.
- Arbitration is round-robin: search starts at last_owner+1 modulo NUM_REQ. last_owner resets to NUM_REQ-1, so requester 0 wins first after reset.
- SETUP: psel=1, penable=0. The FSM moves unconditionally to ACCESS, and pready is ignored in this state.
- ACCESS: psel=1, penable=1. Address, data and control stay stable.
  - pready=1 → complete normally.
  - pready=0 → increment wait_cnt.
  - wait_cnt reaching TIMEOUT (only if TIMEOUT≠0) → abort.
- Complete (normal), next cycle:
  - ack[owner]=1.
  - rsp_rdata = prdata captured at the pready edge, for reads only. For writes it holds its previous value.
  - rsp_err=0.
- Abort (timeout), next cycle:
  - ack[owner]=1 and rsp_err=1.
  - rsp_rdata is left unchanged.
  - The FSM returns to IDLE with psel=0.
- Back-to-back on normal completion:
  - The arbiter runs on the same edge and excludes the current owner, because its req is still high.
  - If another requester is pending, the FSM goes directly to SETUP (psel stays 1, penable drops to 0) with the new winner's fields.
  - Otherwise it goes to IDLE.
- After seeing ack, a requester may keep req high to issue a new request. It competes in the following arbitration.
- wait_cnt clears on every entry to SETUP. Its width is enough to hold TIMEOUT.
- Request fields are sampled only at grant. Later changes have no effect on the transfer in progress.

## Timing
- Reset values: psel, penable, pwrite=0; paddr, pwdata, pstrb=0; ack=0; rsp_err=0; rsp_rdata=0. FSM in IDLE, wait_cnt=0.
- Reset mid-transfer: all outputs drop to their reset values immediately and asynchronously. No ack is issued for the aborted transfer.
- Single transfer, req rising in cycle 0, with pready in the first ACCESS cycle:
  - SETUP in cycle 1, ACCESS in cycle 2.
  - ack plus data in cycle 3.
  - Latency is 3 cycles.
- Each additional pready-low ACCESS cycle adds 1 cycle of latency.
- Back-to-back transfers: a new SETUP begins in the same cycle as the previous ack, giving 2 cycles per transfer.
- Timeout: with pready held low, the abort ack appears TIMEOUT+1 cycles after the ACCESS entry.
- At most one ack bit is high in any cycle, and ack never coincides with psel=0→1 for the same owner.

## Test plan
- Single write (requester 2, addr 0x010, wdata 0xDEADBEEF, strb 0xF), slave ready in first ACCESS → psel in cycle 1, penable in cycle 2, ack=4'b0100 in cycle 3, rsp_err=0.
- Single read (requester 0, addr 0x020), prdata=0x12345678 → rsp_rdata=0x12345678 with ack=4'b0001 and pwrite=0 throughout.
- All four req held high → grant order 0,1,2,3,0. SETUP follows each ack with no IDLE gap, 2 cycles per transfer.
- pready held low with TIMEOUT=16 → ack plus rsp_err=1 exactly 17 cycles after ACCESS entry, then psel=0.
- rst_n asserted during ACCESS → psel/penable go to 0 asynchronously and no ack. After release, requester 0 wins first.
- Requester changes req_addr after grant → paddr unchanged until completion.
